// File: rtl/mul_acc_if.sv
// Handshake bundle between the multiplier product stream, the accumulation stage and its consumer.
// The master modport belongs to the producer/consumer side. The slave modport belongs to mul_acc_stage.
interface mul_acc_if #(
  parameter int DWIDTH  = 11,
  parameter int ACC_LEN = 4
);
  localparam int GW = $clog2(ACC_LEN);
  localparam int SW = 2*DWIDTH + GW;

  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [2*DWIDTH-1:0]  in_prod_i;
  logic                 flush_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [SW-1:0]        out_sum_o;
  logic [GW:0]          out_cnt_o;

  modport master (
    output in_valid_i, in_prod_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_sum_o, out_cnt_o
  );

  modport slave (
    input  in_valid_i, in_prod_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, out_sum_o, out_cnt_o
  );
endinterface

// File: rtl/mul_acc_stage.sv
// Sums groups of ACC_LEN signed products in a guard-extended accumulator.
// Each group sum is held in a single-entry valid/ready output register, and a flush closes a partial group early.
module mul_acc_stage #(
  parameter int DWIDTH  = 11,
  parameter int ACC_LEN = 4
) (
  input  logic     clk,
  input  logic     rst,
  mul_acc_if.slave bus
);
  localparam int GW = $clog2(ACC_LEN);
  localparam int PW = 2*DWIDTH;
  localparam int SW = PW + GW;
  localparam logic [GW-1:0] LAST_CNT = GW'(ACC_LEN-1);

  logic signed [SW-1:0] r_acc;
  logic [GW-1:0]        r_cnt;
  logic signed [SW-1:0] r_outSum;
  logic [GW:0]          r_outCnt;
  logic                 r_outValid;
  logic                 r_flushPend;

  logic                 w_slotFree;
  logic                 w_lastBeat;
  logic                 w_inReady;
  logic                 w_inHs;
  logic                 w_flushExec;
  logic                 w_close;
  logic signed [SW-1:0] w_prodExt;
  logic signed [SW-1:0] w_addend;
  logic signed [SW-1:0] w_total;
  logic [GW:0]          w_cntNext;

  assign w_slotFree  = !r_outValid | bus.out_ready_i;
  assign w_lastBeat  = (r_cnt == LAST_CNT);
  // Only the beat that closes a group has to wait for the output slot.
  assign w_inReady   = !r_flushPend & (!w_lastBeat | w_slotFree);
  assign w_inHs      = bus.in_valid_i & w_inReady;
  assign w_flushExec = (bus.flush_i | r_flushPend) & w_slotFree;
  assign w_close     = (w_inHs & w_lastBeat) | (w_flushExec & ((r_cnt != '0) | w_inHs));

  assign w_prodExt   = {{GW{bus.in_prod_i[PW-1]}}, bus.in_prod_i};
  assign w_addend    = w_inHs ? w_prodExt : '0;
  assign w_total     = r_acc + w_addend;
  assign w_cntNext   = {1'b0, r_cnt} + {{GW{1'b0}}, w_inHs};

  assign bus.in_ready_o  = w_inReady;
  assign bus.out_valid_o = r_outValid;
  assign bus.out_sum_o   = r_outSum;
  assign bus.out_cnt_o   = r_outCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_outSum    <= '0;
      r_outCnt    <= '0;
      r_outValid  <= 1'b0;
      r_flushPend <= 1'b0;
    end else begin
      if (w_close) begin
        r_outSum   <= w_total;
        r_outCnt   <= w_cntNext;
        r_outValid <= 1'b1;
        r_acc      <= '0;
        r_cnt      <= '0;
      end else begin
        if (bus.out_ready_i)
          r_outValid <= 1'b0;
        if (w_inHs) begin
          r_acc <= w_total;
          r_cnt <= r_cnt + GW'(1);
        end
      end
      // A flush that cannot execute yet is remembered until the slot drains.
      if (w_flushExec)
        r_flushPend <= 1'b0;
      else if (bus.flush_i)
        r_flushPend <= 1'b1;
    end
  end
endmodule
